// File: rtl/iq_sample_buffer_if.sv
// I/Q capture and 16-bit serialized output stream bundle.
// master = decimator/consumer side, slave = the buffer.
interface iq_sample_buffer_if;
    logic        strobe_in;
    logic [15:0] i_in;
    logic [15:0] q_in;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_is_q;

    modport master (
        output strobe_in, i_in, q_in, out_ready,
        input  out_valid, out_data, out_is_q
    );

    modport slave (
        input  strobe_in, i_in, q_in, out_ready,
        output out_valid, out_data, out_is_q
    );
endinterface

// File: rtl/iq_sample_buffer.sv
// Elastic buffer: captures decimated I/Q pairs, replays them as I then Q words on a valid/ready stream.
// Latency 1 cycle from strobe to first word; input cannot be back-pressured, so overflow drops and counts.
module iq_sample_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    iq_sample_buffer_if.slave   bus,
    input  logic                clear_overrun,
    output logic [ADDR_W:0]     level,
    output logic                overrun_flag,
    output logic [15:0]         overrun_count
);
    typedef enum logic {PH_I, PH_Q} phase_t;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    phase_t          phase_q, phase_d;
    logic            ovf_flag_q, ovf_flag_d;
    logic [15:0]     ovf_cnt_q, ovf_cnt_d;

    logic        full, empty, push, drop, fire;
    logic [31:0] rd_entry;

    always_comb begin
        // Pointers carry one extra wrap bit: equal means empty, differing only in MSB means full.
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}});
        push     = bus.strobe_in & ~full;
        drop     = bus.strobe_in & full;
        fire     = ~empty & bus.out_ready;
        rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        phase_d  = phase_q;
        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = {bus.i_in, bus.q_in};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fire) begin
            if (phase_q == PH_Q) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                phase_d  = PH_I;
            end else begin
                phase_d  = PH_Q;
            end
        end

        ovf_flag_d = ovf_flag_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (clear_overrun) begin
            ovf_flag_d = 1'b0;
            ovf_cnt_d  = 16'h0000;
        end else if (drop) begin
            ovf_flag_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            phase_q    <= PH_I;
            ovf_flag_q <= 1'b0;
            ovf_cnt_q  <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            phase_q    <= phase_d;
            ovf_flag_q <= ovf_flag_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Sample storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_valid = ~empty;
    assign bus.out_is_q  = (phase_q == PH_Q);
    assign bus.out_data  = (phase_q == PH_Q) ? rd_entry[15:0] : rd_entry[31:16];
    assign level         = wr_ptr_q - rd_ptr_q;
    assign overrun_flag  = ovf_flag_q;
    assign overrun_count = ovf_cnt_q;
endmodule

// File: tb/tb_iq_sample_buffer.sv
// Randomized and directed bench for iq_sample_buffer against a queue-based reference model.
module tb_iq_sample_buffer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear_overrun;
    logic [ADDR_W:0]   level;
    logic              overrun_flag;
    logic [15:0]       overrun_count;

    iq_sample_buffer_if bus();

    iq_sample_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .clear_overrun (clear_overrun),
        .level         (level),
        .overrun_flag  (overrun_flag),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored pairs plus which half of the head pair is next.
    logic [31:0] mq[$];
    bit          m_next_is_q;
    bit          m_flag;
    int unsigned m_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("out_data", {16'd0, bus.out_data},
                {16'd0, m_next_is_q ? mq[0][15:0] : mq[0][31:16]});
            chk("out_is_q", {31'd0, bus.out_is_q}, {31'd0, m_next_is_q});
        end
        chk("level", {27'd0, level}, mq.size());
        chk("overrun_flag", {31'd0, overrun_flag}, {31'd0, m_flag});
        chk("overrun_count", {16'd0, overrun_count}, m_cnt);
    endtask

    task automatic model_step(input bit s, input logic [15:0] i, input logic [15:0] q,
                              input bit rdy, input bit clr, input bit rst);
        bit was_full;
        if (rst) begin
            mq.delete();
            m_next_is_q = 0;
            m_flag      = 0;
            m_cnt       = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        if (mq.size() != 0 && rdy) begin
            if (m_next_is_q) void'(mq.pop_front());
            m_next_is_q = !m_next_is_q;
        end
        if (s && !was_full) mq.push_back({i, q});
        if (clr) begin
            m_flag = 0;
            m_cnt  = 0;
        end else if (s && was_full) begin
            m_flag = 1;
            if (m_cnt < 32'hFFFF) m_cnt++;
        end
    endtask

    // One clock: check settled outputs, apply inputs, advance model on the edge.
    task automatic cyc(input bit s, input logic [15:0] i, input logic [15:0] q,
                       input bit rdy, input bit clr, input bit rst);
        @(negedge clk);
        check_all();
        bus.strobe_in = s;
        bus.i_in      = i;
        bus.q_in      = q;
        bus.out_ready = rdy;
        clear_overrun = clr;
        reset         = rst;
        @(posedge clk);
        model_step(s, i, q, rdy, clr, rst);
    endtask

    logic [15:0] bp_exp[6];
    logic [15:0] ri, rq;

    initial begin
        bus.strobe_in = 0;
        bus.i_in      = 0;
        bus.q_in      = 0;
        bus.out_ready = 0;
        clear_overrun = 0;
        reset         = 1;
        repeat (2) @(posedge clk);
        model_step(0, 0, 0, 0, 0, 1);

        // Single pair, consumer ready.
        cyc(1, 16'h1234, 16'hABCD, 1, 0, 0);
        #1 chk("single_i", {16'd0, bus.out_data}, 32'h1234);
        chk("single_i_tag", {31'd0, bus.out_is_q}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        #1 chk("single_q", {16'd0, bus.out_data}, 32'hABCD);
        chk("single_q_tag", {31'd0, bus.out_is_q}, 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        #1 chk("single_empty", {31'd0, bus.out_valid}, 32'd0);
        chk("single_level", {27'd0, level}, 32'd0);

        // Back-pressure with three pairs, then a full-rate drain.
        for (int k = 0; k < 3; k++) begin
            ri = 16'($urandom);
            rq = 16'($urandom);
            bp_exp[2*k]   = ri;
            bp_exp[2*k+1] = rq;
            cyc(1, ri, rq, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        #1 chk("bp_level", {27'd0, level}, 32'd3);
        chk("bp_hold", {16'd0, bus.out_data}, {16'd0, bp_exp[0]});
        for (int k = 0; k < 6; k++) begin
            chk("bp_order", {16'd0, bus.out_data}, {16'd0, bp_exp[k]});
            cyc(0, 0, 0, 1, 0, 0);
            #1;
        end
        chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // Fill and overrun, then ordered drain.
        cyc(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 20; n++) cyc(1, 16'(n), ~16'(n), 0, 0, 0);
        #1 chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_flag", {31'd0, overrun_flag}, 32'd1);
        chk("fill_count", {16'd0, overrun_count}, 32'd4);
        for (int n = 0; n < 16; n++) begin
            chk("drain_i", {16'd0, bus.out_data}, n);
            cyc(0, 0, 0, 1, 0, 0);
            #1 chk("drain_q", {16'd0, bus.out_data}, {16'd0, ~16'(n)});
            cyc(0, 0, 0, 1, 0, 0);
            #1;
        end

        // Push while full in PH_Q and popping the same cycle.
        cyc(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < DEPTH; n++) cyc(1, 16'(n), 16'(n), 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 16'h5555, 16'h6666, 1, 0, 0);
        #1 chk("fullpop_level", {27'd0, level}, 32'd15);
        chk("fullpop_count", {16'd0, overrun_count}, 32'd1);

        // Saturation, then clear coinciding with a drop.
        cyc(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < DEPTH; n++) cyc(1, 16'(n), 16'(n), 0, 0, 0);
        for (int n = 0; n < 65537; n++) cyc(1, 16'h0BAD, 16'h0BAD, 0, 0, 0);
        #1 chk("sat_count", {16'd0, overrun_count}, 32'hFFFF);
        cyc(1, 16'h0BAD, 16'h0BAD, 0, 1, 0);
        #1 chk("clr_flag", {31'd0, overrun_flag}, 32'd0);
        chk("clr_count", {16'd0, overrun_count}, 32'd0);

        // Reset mid-stream in PH_Q.
        cyc(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 5; n++) cyc(1, 16'(n + 100), 16'(n + 200), 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        #1 chk("mid_phase_q", {31'd0, bus.out_is_q}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        #1 chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_is_q", {31'd0, bus.out_is_q}, 32'd0);
        cyc(1, 16'hC0DE, 16'hFACE, 0, 0, 0);
        #1 chk("rst_first_i", {16'd0, bus.out_data}, 32'hC0DE);
        chk("rst_first_tag", {31'd0, bus.out_is_q}, 32'd0);

        // Randomized traffic including back-to-back strobes, clears and resets.
        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                $urandom_range(0, 300) == 0);
        end
        @(negedge clk);
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
